// File: rtl/sa_dma_sequencer.sv
// Block sequencer: per block, NUM_RD_CH strided read bursts, one core run, one write burst,
// using run-time config latched at start; adds response-error capture, watchdog and abort.
module sa_dma_sequencer #(
   parameter int ADDR_W    = 32,
   parameter int BIT_TRANS = 8,
   parameter int BLK_W     = 16,
   parameter int NUM_RD_CH = 2,
   parameter int CH_W      = (NUM_RD_CH > 1) ? $clog2(NUM_RD_CH) : 1,
   parameter int TMO_W     = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        i_start,
   input  logic                        i_abort,
   input  logic [NUM_RD_CH*ADDR_W-1:0] i_rd_base,
   input  logic [ADDR_W-1:0]           i_wr_base,
   input  logic [ADDR_W-1:0]           i_rd_stride,
   input  logic [ADDR_W-1:0]           i_wr_stride,
   input  logic [BIT_TRANS-1:0]        i_num_trans,
   input  logic [BLK_W-1:0]            i_num_blk,
   input  logic [TMO_W-1:0]            i_timeout,
   output logic                        o_rd_start,
   output logic [ADDR_W-1:0]           o_rd_addr,
   output logic [CH_W-1:0]             o_rd_ch,
   input  logic                        i_rd_done,
   input  logic                        i_rd_err,
   output logic                        o_wr_start,
   output logic [ADDR_W-1:0]           o_wr_addr,
   input  logic                        i_wr_done,
   input  logic                        i_wr_err,
   output logic [BIT_TRANS-1:0]        o_num_trans,
   output logic                        o_core_go,
   output logic [BLK_W-1:0]            o_blk_idx,
   input  logic                        i_core_done,
   output logic                        o_busy,
   output logic                        o_done,
   output logic                        o_error,
   output logic [2:0]                  o_err_code
);

   typedef enum logic [2:0] {
      IDLE, RD_ISSUE, RD_WAIT, CORE_GO, CORE_WAIT, WR_ISSUE, WR_WAIT, FIN
   } state_t;

   localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_RD_CH - 1);

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] rd_ptr [NUM_RD_CH];
   logic [ADDR_W-1:0] wr_ptr, rd_stride, wr_stride;
   logic [BLK_W-1:0]  num_blk, blk;
   logic [CH_W-1:0]   ch;
   logic [TMO_W-1:0]  timeout, wd_cnt;
   logic [TMO_W:0]    wd_inc;
   logic              start_ok, cfg_zero, in_wait, tmo_hit, last_blk, err_hit;
   logic [2:0]        err_code;

   assign start_ok = (state == IDLE) && i_start;
   assign cfg_zero = (i_num_blk == '0) || (i_num_trans == '0);
   assign in_wait  = (state == RD_WAIT) || (state == CORE_WAIT) || (state == WR_WAIT);
   assign wd_inc   = {1'b0, wd_cnt} + {{TMO_W{1'b0}}, 1'b1};
   assign tmo_hit  = in_wait && (timeout != '0) && (wd_inc == {1'b0, timeout});
   assign last_blk = (blk == num_blk - BLK_W'(1));
   assign o_rd_ch   = ch;
   assign o_blk_idx = blk;

   // Abort beats response errors, which beat the watchdog; any of them beats a done.
   always_comb begin
      err_hit  = 1'b0;
      err_code = 3'd0;
      if (state != IDLE) begin
         if (i_abort) begin
            err_hit  = 1'b1;
            err_code = 3'd4;
         end else if ((state == RD_WAIT) && i_rd_err) begin
            err_hit  = 1'b1;
            err_code = 3'd1;
         end else if ((state == WR_WAIT) && i_wr_err) begin
            err_hit  = 1'b1;
            err_code = 3'd2;
         end else if (tmo_hit) begin
            err_hit  = 1'b1;
            err_code = 3'd3;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (i_start) state_nxt = cfg_zero ? FIN : RD_ISSUE;
         RD_ISSUE:  state_nxt = RD_WAIT;
         RD_WAIT:   if (i_rd_done) state_nxt = (ch == LAST_CH) ? CORE_GO : RD_ISSUE;
         CORE_GO:   state_nxt = CORE_WAIT;
         CORE_WAIT: if (i_core_done) state_nxt = WR_ISSUE;
         WR_ISSUE:  state_nxt = WR_WAIT;
         WR_WAIT:   if (i_wr_done) state_nxt = last_blk ? FIN : RD_ISSUE;
         FIN:       state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
      if (err_hit) state_nxt = IDLE;
   end

   always_comb begin
      o_rd_start = (state == RD_ISSUE);
      o_core_go  = (state == CORE_GO);
      o_wr_start = (state == WR_ISSUE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NUM_RD_CH; k++) rd_ptr[k] <= '0;
         wr_ptr      <= '0;
         rd_stride   <= '0;
         wr_stride   <= '0;
         num_blk     <= '0;
         timeout     <= '0;
         blk         <= '0;
         ch          <= '0;
         wd_cnt      <= '0;
         o_rd_addr   <= '0;
         o_wr_addr   <= '0;
         o_num_trans <= '0;
         o_busy      <= 1'b0;
         o_done      <= 1'b0;
         o_error     <= 1'b0;
         o_err_code  <= 3'd0;
      end else begin
         o_busy <= (state_nxt != IDLE);
         // Any state change restarts the count, so every wait state is timed from its entry.
         wd_cnt <= (state_nxt != state) ? '0 : wd_inc[TMO_W-1:0];
         if (start_ok) begin
            for (int k = 0; k < NUM_RD_CH; k++) rd_ptr[k] <= i_rd_base[k*ADDR_W +: ADDR_W];
            wr_ptr      <= i_wr_base;
            rd_stride   <= i_rd_stride;
            wr_stride   <= i_wr_stride;
            num_blk     <= i_num_blk;
            timeout     <= i_timeout;
            o_num_trans <= i_num_trans;
            blk         <= '0;
            ch          <= '0;
            o_rd_addr   <= i_rd_base[ADDR_W-1:0];
            o_done      <= 1'b0;
            o_error     <= 1'b0;
            o_err_code  <= 3'd0;
         end else if (err_hit) begin
            o_error    <= 1'b1;
            o_err_code <= err_code;
         end else begin
            case (state)
               RD_WAIT: if (i_rd_done) begin
                  rd_ptr[ch] <= rd_ptr[ch] + rd_stride;
                  if (ch == LAST_CH) begin
                     ch <= '0;
                  end else begin
                     ch        <= ch + CH_W'(1);
                     o_rd_addr <= rd_ptr[ch + CH_W'(1)];
                  end
               end
               CORE_WAIT: if (i_core_done) o_wr_addr <= wr_ptr;
               WR_WAIT: if (i_wr_done) begin
                  wr_ptr <= wr_ptr + wr_stride;
                  if (!last_blk) begin
                     blk       <= blk + BLK_W'(1);
                     o_rd_addr <= rd_ptr[0];
                  end
               end
               FIN:     o_done <= 1'b1;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sa_dma_sequencer.sv
// Randomized bench: per-job expected burst lists from base + index*stride arithmetic, with
// DMA/core responders, injected errors, watchdog expiry and abort.
module tb_sa_dma_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_start, i_abort;
   logic [63:0] i_rd_base;
   logic [31:0] i_wr_base, i_rd_stride, i_wr_stride;
   logic [7:0]  i_num_trans;
   logic [15:0] i_num_blk, i_timeout;
   logic        o_rd_start;
   logic [31:0] o_rd_addr;
   logic [0:0]  o_rd_ch;
   logic        i_rd_done, i_rd_err;
   logic        o_wr_start;
   logic [31:0] o_wr_addr;
   logic        i_wr_done, i_wr_err;
   logic [7:0]  o_num_trans;
   logic        o_core_go;
   logic [15:0] o_blk_idx;
   logic        i_core_done;
   logic        o_busy, o_done, o_error;
   logic [2:0]  o_err_code;

   int n_cmp = 0;
   int n_bad = 0;

   sa_dma_sequencer dut (
      .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort),
      .i_rd_base(i_rd_base), .i_wr_base(i_wr_base), .i_rd_stride(i_rd_stride),
      .i_wr_stride(i_wr_stride), .i_num_trans(i_num_trans), .i_num_blk(i_num_blk),
      .i_timeout(i_timeout), .o_rd_start(o_rd_start), .o_rd_addr(o_rd_addr),
      .o_rd_ch(o_rd_ch), .i_rd_done(i_rd_done), .i_rd_err(i_rd_err),
      .o_wr_start(o_wr_start), .o_wr_addr(o_wr_addr), .i_wr_done(i_wr_done),
      .i_wr_err(i_wr_err), .o_num_trans(o_num_trans), .o_core_go(o_core_go),
      .o_blk_idx(o_blk_idx), .i_core_done(i_core_done), .o_busy(o_busy),
      .o_done(o_done), .o_error(o_error), .o_err_code(o_err_code)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      i_start = 0; i_abort = 0; i_rd_done = 0; i_rd_err = 0;
      i_core_done = 0; i_wr_done = 0; i_wr_err = 0;
   endtask

   // fk: 0 none, 1 rd_err on read burst fi, 2 wr_err on block fi, 3 core hang on block fi, 4 abort with wr_done on block fi
   task automatic run_job(input int nblk, input int ntr, input logic [31:0] b0, input logic [31:0] b1,
                          input logic [31:0] rs, input logic [31:0] wb, input logic [31:0] ws,
                          input int tmo, input int fk, input int fi);
      logic [31:0] exp_rd[$];
      logic [31:0] exp_wr[$];
      int exp_ch[$];
      int exp_bk[$];
      int e_rd, e_core, e_wr, e_code;
      int n_rd, n_core, n_wr, rd_cnt, core_cnt, wr_cnt, due, go_k, err_k, k_end;
      bit rd_pend, core_pend, wr_pend, zero;
      logic [31:0] cur_rd, cur_wr;
      n_rd = 0; n_core = 0; n_wr = 0; rd_cnt = 0; core_cnt = 0; wr_cnt = 0;
      due = 0; go_k = -1; err_k = -1; k_end = -1;
      rd_pend = 0; core_pend = 0; wr_pend = 0; cur_rd = '0; cur_wr = '0;

      zero = (nblk == 0) || (ntr == 0);
      for (int b = 0; b < nblk; b++) begin
         for (int c = 0; c < 2; c++) begin
            exp_rd.push_back(((c == 0) ? b0 : b1) + rs * 32'(b));
            exp_ch.push_back(c);
            exp_bk.push_back(b);
         end
         exp_wr.push_back(wb + ws * 32'(b));
      end
      case (fk)
         1:       begin e_rd = fi + 1;       e_core = fi / 2; e_wr = fi / 2; e_code = 1; end
         2:       begin e_rd = (fi + 1) * 2; e_core = fi + 1; e_wr = fi + 1; e_code = 2; end
         3:       begin e_rd = (fi + 1) * 2; e_core = fi + 1; e_wr = fi;     e_code = 3; end
         4:       begin e_rd = (fi + 1) * 2; e_core = fi + 1; e_wr = fi + 1; e_code = 4; end
         default: begin
            e_rd = zero ? 0 : nblk * 2; e_core = zero ? 0 : nblk; e_wr = e_core; e_code = 0;
         end
      endcase

      i_rd_base = {b1, b0}; i_wr_base = wb; i_rd_stride = rs; i_wr_stride = ws;
      i_num_trans = 8'(ntr); i_num_blk = 16'(nblk); i_timeout = 16'(tmo);
      i_start = 1;
      for (int k = 0; k < 3000; k++) begin
         step();
         clear_inputs();
         if (k == 0) begin
            chk("busy_rise", o_busy, 1);
            chk("err_clr", o_error, 0);
            chk("done_clr", o_done, 0);
            if (!zero) chk("first_rd", o_rd_start, 1);
         end
         if (!o_busy) begin
            k_end = k;
            break;
         end
         if (k == 2) begin
            i_start = 1;
            i_rd_base = ~i_rd_base;
            i_num_blk = 16'(nblk + 3);
         end
         case (due)
            1:       chk("rd_lat", o_rd_start, 1);
            2:       chk("go_lat", o_core_go, 1);
            3:       chk("wr_lat", o_wr_start, 1);
            default: ;
         endcase
         due = 0;
         if (rd_pend) begin
            chk("rd_hold", o_rd_addr, cur_rd);
            rd_cnt--;
            if (rd_cnt == 0) begin
               rd_pend = 0; i_rd_done = 1;
               if (fk == 1 && n_rd - 1 == fi) begin i_rd_err = 1; err_k = k; end
               else due = (exp_ch[n_rd-1] == 1) ? 2 : 1;
            end
         end
         if (core_pend) begin
            core_cnt--;
            if (core_cnt == 0) begin core_pend = 0; i_core_done = 1; due = 3; end
         end
         if (wr_pend) begin
            chk("wr_hold", o_wr_addr, cur_wr);
            wr_cnt--;
            if (wr_cnt == 0) begin
               wr_pend = 0; i_wr_done = 1;
               if (fk == 2 && n_wr - 1 == fi) begin i_wr_err = 1; err_k = k; end
               else if (fk == 4 && n_wr - 1 == fi) begin i_abort = 1; err_k = k; end
               else if (n_wr < nblk) due = 1;
            end
         end
         if (o_rd_start) begin
            n_rd++;
            if (n_rd <= exp_rd.size()) begin
               cur_rd = exp_rd[n_rd-1];
               chk("rd_addr", o_rd_addr, exp_rd[n_rd-1]);
               chk("rd_ch", o_rd_ch, exp_ch[n_rd-1]);
               chk("rd_blk", o_blk_idx, exp_bk[n_rd-1]);
            end
            chk("num_trans", o_num_trans, ntr);
            rd_pend = 1; rd_cnt = $urandom_range(1, 4);
         end
         if (o_core_go) begin
            n_core++;
            chk("go_blk", o_blk_idx, n_core - 1);
            if (fk == 3 && n_core - 1 == fi) go_k = k;
            else begin core_pend = 1; core_cnt = $urandom_range(1, 4); end
         end
         if (o_wr_start) begin
            n_wr++;
            if (n_wr <= exp_wr.size()) begin
               cur_wr = exp_wr[n_wr-1];
               chk("wr_addr", o_wr_addr, exp_wr[n_wr-1]);
            end
            chk("wr_blk", o_blk_idx, n_wr - 1);
            wr_pend = 1; wr_cnt = $urandom_range(1, 4);
         end
      end
      clear_inputs();
      if (k_end < 0) chk("job_budget", 0, 1);
      chk("n_rd", n_rd, e_rd);
      chk("n_core", n_core, e_core);
      chk("n_wr", n_wr, e_wr);
      chk("done", o_done, e_code == 0);
      chk("error", o_error, e_code != 0);
      chk("err_code", o_err_code, e_code);
      if (zero && fk == 0) chk("zero_lat", k_end, 1);
      if (fk == 3) chk("tmo_lat", k_end, go_k + tmo + 1);
      if (fk == 1 || fk == 2 || fk == 4) chk("err_lat", k_end, err_k + 1);
      step();
      step();
      chk("done_sticky", o_done, e_code == 0);
      chk("code_sticky", o_err_code, e_code);
      chk("idle_busy", o_busy, 0);
   endtask

   int nb, fk, fi, tmo;

   initial begin
      rst = 1;
      clear_inputs();
      i_rd_base = '0; i_wr_base = '0; i_rd_stride = '0; i_wr_stride = '0;
      i_num_trans = '0; i_num_blk = '0; i_timeout = '0;
      repeat (3) step();
      chk("rst_pulses", {o_rd_start, o_wr_start, o_core_go}, 0);
      chk("rst_status", {o_busy, o_done, o_error, o_err_code}, 0);
      chk("rst_rd", {o_rd_ch, o_rd_addr}, 0);
      chk("rst_wr", o_wr_addr, 0);
      chk("rst_blk", o_blk_idx, 0);
      chk("rst_ntr", o_num_trans, 0);
      rst = 0;
      step();

      run_job(3, 16, 32'h1000, 32'h2000, 32'h40, 32'h3000, 32'h40, 0, 0, 0);
      i_abort = 1;
      step();
      i_abort = 0;
      step();
      chk("idle_abort_err", o_error, 0);
      chk("idle_abort_done", o_done, 1);

      run_job(0, 16, 32'h1000, 32'h2000, 32'h40, 32'h3000, 32'h40, 0, 0, 0);
      run_job(2, 0, 32'h1000, 32'h2000, 32'h40, 32'h3000, 32'h40, 0, 0, 0);
      run_job(3, 16, 32'h1000, 32'h2000, 32'h40, 32'h3000, 32'h40, 0, 1, 3);
      run_job(2, 16, 32'h1000, 32'h2000, 32'h40, 32'h3000, 32'h40, 0, 0, 0);
      run_job(2, 16, 32'h1000, 32'h2000, 32'h40, 32'h3000, 32'h40, 10, 3, 0);
      run_job(3, 16, 32'h1000, 32'h2000, 32'h40, 32'h3000, 32'h40, 0, 4, 1);
      run_job(2, 8, 32'hFFFF_FFC0, 32'h5000, 32'h40, 32'hFFFF_FFC0, 32'h40, 0, 0, 0);
      run_job(2, 8, 32'h100, 32'h200, 32'h80, 32'h400, 32'h80, 0, 2, 1);

      for (int j = 0; j < 12; j++) begin
         nb = $urandom_range(1, 5);
         fk = $urandom_range(0, 4);
         fi = (fk == 1) ? $urandom_range(0, nb * 2 - 1) : $urandom_range(0, nb - 1);
         if (fk == 3) tmo = $urandom_range(6, 30);
         else tmo = ($urandom_range(0, 1) == 1) ? $urandom_range(6, 50) : 0;
         run_job(nb, $urandom_range(1, 255), $urandom, $urandom, $urandom & 32'hFFF0,
                 $urandom, $urandom & 32'hFFF0, tmo, fk, fi);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
